// File: rtl/tmds_link_ctrl.sv
// Raster timing generator feeding three TMDS encoders (blue/green/red) with registered symbols.
// Define TMDS_LINK_CTRL_PATTERN_EN to build in the 8-bar colour test pattern selected by test_mode.

module tmds_encoder (
    input  logic [7:0] d,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    input  logic [4:0] cnt_prev,
    output logic [9:0] q,
    output logic [4:0] cnt
);
    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Transition-minimising stage: XOR or XNOR chain, choice recorded in bit 8.
    function automatic logic [8:0] minimise(input logic [7:0] din);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] m;
        ones = '0;
        for (int i = 0; i < 8; i++) ones = ones + 4'(din[i]);
        use_xnor = (ones > 4'd4) || (ones == 4'd4 && !din[0]);
        m[0] = din[0];
        for (int i = 1; i < 8; i++)
            m[i] = use_xnor ? ~(m[i-1] ^ din[i]) : (m[i-1] ^ din[i]);
        m[8] = ~use_xnor;
        return m;
    endfunction

    logic [8:0]        q_m;
    logic [3:0]        n1_q;
    logic signed [4:0] disp;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_next;

    always_comb begin
        // NOTE: every output gets a default first so no path through the branches infers a latch.
        q        = CTRL_00;
        cnt_next = 5'sd0;
        q_m      = minimise(d);
        n1_q     = '0;
        for (int i = 0; i < 8; i++) n1_q = n1_q + 4'(q_m[i]);
        disp = $signed(cnt_prev);
        // Modulo-32 arithmetic is exact here: |disparity| never exceeds 15.
        diff = $signed({n1_q, 1'b0}) - 5'sd8;

        if (!de) begin
            unique case ({c1, c0})
                2'b00: q = CTRL_00;
                2'b01: q = CTRL_01;
                2'b10: q = CTRL_10;
                2'b11: q = CTRL_11;
            endcase
        end else if (disp == 5'sd0 || diff == 5'sd0) begin
            q        = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_next = q_m[8] ? disp + diff : disp - diff;
        end else if ((disp > 5'sd0 && diff > 5'sd0) || (disp < 5'sd0 && diff < 5'sd0)) begin
            q        = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_next = disp + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            q        = {1'b0, q_m[8], q_m[7:0]};
            cnt_next = disp - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
        end
        cnt = cnt_next;
    end
endmodule

module tmds_link_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        test_mode,
    input  logic [7:0]  rgb_r,
    input  logic [7:0]  rgb_g,
    input  logic [7:0]  rgb_b,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        px_de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  CTRL_IDLE = 10'b1101010100;

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [9:0]  sym_b, sym_g, sym_r;
    logic [4:0]  disp_b, disp_g, disp_r;
    logic [4:0]  disp_b_next, disp_g_next, disp_r_next;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst || !en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
            h_cnt <= h_cnt + 12'd1;
        end
    end

    assign px_x        = h_cnt;
    assign px_y        = v_cnt;
    assign px_de       = en && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hsync       = (en && h_cnt >= HS_BEG && h_cnt < HS_END) ? HS_POL : ~HS_POL;
    assign vsync       = (en && v_cnt >= VS_BEG && v_cnt < VS_END) ? VS_POL : ~VS_POL;
    assign frame_start = en && (h_cnt == 12'd0) && (v_cnt == 12'd0);

`ifdef TMDS_LINK_CTRL_PATTERN_EN
    localparam logic [11:0] BAR1 = 12'(H_ACTIVE / 8 * 1);
    localparam logic [11:0] BAR2 = 12'(H_ACTIVE / 8 * 2);
    localparam logic [11:0] BAR3 = 12'(H_ACTIVE / 8 * 3);
    localparam logic [11:0] BAR4 = 12'(H_ACTIVE / 8 * 4);
    localparam logic [11:0] BAR5 = 12'(H_ACTIVE / 8 * 5);
    localparam logic [11:0] BAR6 = 12'(H_ACTIVE / 8 * 6);
    localparam logic [11:0] BAR7 = 12'(H_ACTIVE / 8 * 7);

    logic [23:0] bar_rgb;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        if      (h_cnt < BAR1) bar_rgb = 24'hFFFFFF;
        else if (h_cnt < BAR2) bar_rgb = 24'hFFFF00;
        else if (h_cnt < BAR3) bar_rgb = 24'h00FFFF;
        else if (h_cnt < BAR4) bar_rgb = 24'h00FF00;
        else if (h_cnt < BAR5) bar_rgb = 24'hFF00FF;
        else if (h_cnt < BAR6) bar_rgb = 24'hFF0000;
        else if (h_cnt < BAR7) bar_rgb = 24'h0000FF;
        else                   bar_rgb = 24'h000000;
        {pix_r, pix_g, pix_b} = test_mode ? bar_rgb : {rgb_r, rgb_g, rgb_b};
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign pix_r = rgb_r;
    assign pix_g = rgb_g;
    assign pix_b = rgb_b;
`endif

    tmds_encoder u_enc_b (
        .d(pix_b), .c0(hsync), .c1(vsync), .de(px_de),
        .cnt_prev(disp_b), .q(sym_b), .cnt(disp_b_next)
    );
    tmds_encoder u_enc_g (
        .d(pix_g), .c0(1'b0), .c1(1'b0), .de(px_de),
        .cnt_prev(disp_g), .q(sym_g), .cnt(disp_g_next)
    );
    tmds_encoder u_enc_r (
        .d(pix_r), .c0(1'b0), .c1(1'b0), .de(px_de),
        .cnt_prev(disp_r), .q(sym_r), .cnt(disp_r_next)
    );

    // Symbols and disparity advance together on the edge ending the pixel's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmds_ch0 <= CTRL_IDLE;
            tmds_ch1 <= CTRL_IDLE;
            tmds_ch2 <= CTRL_IDLE;
            disp_b   <= '0;
            disp_g   <= '0;
            disp_r   <= '0;
        end else begin
            tmds_ch0 <= sym_b;
            tmds_ch1 <= sym_g;
            tmds_ch2 <= sym_r;
            disp_b   <= disp_b_next;
            disp_g   <= disp_g_next;
            disp_r   <= disp_r_next;
        end
    end
endmodule

// File: tb/tb_tmds_link_ctrl.sv
// Directed bench for tmds_link_ctrl: horizontal timing at defaults, a short 9-line frame,
// plus a second instance with active-high sync polarity.

module tb_tmds_link_ctrl;
    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic        clk = 1'b0;
    logic        rst, en, test_mode;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic [11:0] px_x, px_y, p_px_x, p_px_y;
    logic        px_de, hsync, vsync, frame_start;
    logic        p_px_de, p_hsync, p_vsync, p_frame_start;
    logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2, p_ch0, p_ch1, p_ch2;

    int passed = 0;
    int fails = 0;
    int total = 0;
    int cyc = 0;
    int cyc0 = 0;
    int fs_seen = 0;

    tmds_link_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut (
        .clk(clk), .rst(rst), .en(en), .test_mode(test_mode),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .px_x(px_x), .px_y(px_y), .px_de(px_de), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .tmds_ch0(tmds_ch0), .tmds_ch1(tmds_ch1), .tmds_ch2(tmds_ch2)
    );

    tmds_link_ctrl #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1'b1), .VS_POL(1'b1)) dut_p (
        .clk(clk), .rst(rst), .en(en), .test_mode(test_mode),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .px_x(p_px_x), .px_y(p_px_y), .px_de(p_px_de), .hsync(p_hsync), .vsync(p_vsync),
        .frame_start(p_frame_start), .tmds_ch0(p_ch0), .tmds_ch1(p_ch1), .tmds_ch2(p_ch2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_start) fs_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int x, input int y);
        int n;
        n = 0;
        while (!(int'(px_x) == x && int'(px_y) == y) && n < 8000) begin
            step();
            n++;
        end
        if (!(int'(px_x) == x && int'(px_y) == y)) begin
            total++;
            fails++;
            $error("FAIL run_to: stuck at x=%0d y=%0d, wanted x=%0d y=%0d", px_x, px_y, x, y);
        end
    endtask

    // Independent TMDS decoder: recovers the pixel byte from a data symbol.
    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] t, d;
        t = s[9] ? ~s[7:0] : s[7:0];
        d[0] = t[0];
        for (int i = 1; i < 8; i++) d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return d;
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; test_mode = 1'b0;
        rgb_r = 8'h00; rgb_g = 8'h00; rgb_b = 8'h00;
        step(); step();
        check("rst_ch0", tmds_ch0, C00);
        check("rst_ch1", tmds_ch1, C00);
        check("rst_ch2", tmds_ch2, C00);
        check("rst_x", px_x, 0);
        check("rst_de_en0", px_de, 0);
        check("rst_fs_en0", frame_start, 0);

        rst = 1'b0; en = 1'b1;
        #1;
        cyc0 = cyc;
        check("start_x", px_x, 0);
        check("start_y", px_y, 0);
        check("start_de", px_de, 1);
        check("start_fs", frame_start, 1);

        // Black pixels from disparity 0: 0 -> -8 -> +2 -> -6.
        step();
        check("blk1_ch0", tmds_ch0, 10'b0100000000);
        check("blk1_ch2", tmds_ch2, 10'b0100000000);
        check("px1_x", px_x, 1);
        check("px1_fs", frame_start, 0);
        step();
        check("blk2_ch0", tmds_ch0, 10'b1111111111);
        check("blk2_ch1", tmds_ch1, 10'b1111111111);
        step();
        check("blk3_ch0", tmds_ch0, 10'b0100000000);
        rgb_r = 8'h55; rgb_g = 8'hFF; rgb_b = 8'h00;
        step();
        check("mix_ch0", tmds_ch0, 10'b1111111111);
        check("mix_ch1", tmds_ch1, 10'b0011111111);
        check("mix_ch2", tmds_ch2, 10'b0100110011);
        rgb_r = 8'h00; rgb_g = 8'h00; rgb_b = 8'h00;

        run_to(640, 0);
        check("fp_de", px_de, 0);
        check("fp_hs", hsync, 1);
        check("fp_hs_pos", p_hsync, 0);
        step();
        check("fp_ch0", tmds_ch0, C11);
        check("fp_ch1", tmds_ch1, C00);
        check("fp_ch2", tmds_ch2, C00);
        run_to(656, 0);
        check("hs_on", hsync, 0);
        check("hs_on_pos", p_hsync, 1);
        step();
        check("hs_ch0", tmds_ch0, C10);
        run_to(751, 0);
        check("hs_last", hsync, 0);
        step();
        check("hs_last_ch0", tmds_ch0, C10);
        check("hs_off", hsync, 1);
        step();
        check("bp_ch0", tmds_ch0, C11);
        run_to(799, 0);
        step();
        check("hwrap_x", px_x, 0);
        check("hwrap_y", px_y, 1);

        run_to(0, 4);
        check("vfp_de", px_de, 0);
        check("vfp_vs", vsync, 1);
        check("vfp_vs_pos", p_vsync, 0);
        run_to(0, 5);
        check("vs_on", vsync, 0);
        check("vs_on_pos", p_vsync, 1);
        step();
        check("vs_only_ch0", tmds_ch0, C01);
        check("vs_ch1", tmds_ch1, C00);
        run_to(656, 5);
        step();
        check("hv_ch0", tmds_ch0, C00);
        run_to(0, 7);
        check("vbp_vs", vsync, 1);

        run_to(799, 8);
        check("pre_wrap_fs", frame_start, 0);
        check("fs_count", fs_seen, 1);
        step();
        check("vwrap_x", px_x, 0);
        check("vwrap_y", px_y, 0);
        check("vwrap_fs", frame_start, 1);
        check("fs_period", cyc - cyc0, 7200);

        run_to(300, 1);
        en = 1'b0;
        #1;
        check("endrop_de", px_de, 0);
        step();
        check("en0_x", px_x, 0);
        check("en0_y", px_y, 0);
        check("en0_de", px_de, 0);
        check("en0_ch0", tmds_ch0, C11);
        check("en0_ch1", tmds_ch1, C00);
        check("en0_ch2", tmds_ch2, C00);
        step();
        check("en0_hold_x", px_x, 0);
        en = 1'b1;
        #1;
        check("reen_fs", frame_start, 1);
        step();
        check("reen_ch0", tmds_ch0, 10'b0100000000);

        run_to(100, 2);
        rst = 1'b1;
        step();
        check("midrst_ch0", tmds_ch0, C00);
        check("midrst_ch1", tmds_ch1, C00);
        check("midrst_ch2", tmds_ch2, C00);
        check("midrst_x", px_x, 0);
        check("midrst_y", px_y, 0);
        rst = 1'b0;
        #1;
        check("postrst_fs", frame_start, 1);
        step();
        check("postrst_ch0", tmds_ch0, 10'b0100000000);
        check("postrst_ch1", tmds_ch1, 10'b0100000000);

`ifdef TMDS_LINK_CTRL_PATTERN_EN
        rgb_r = 8'h12; rgb_g = 8'h34; rgb_b = 8'h56;
        run_to(0, 1);
        test_mode = 1'b1;
        step();
        check("bar_white_ch0", tmds_ch0, 10'b1000000000);
        check("bar_white_ch1", tmds_ch1, 10'b1000000000);
        check("bar_white_ch2", tmds_ch2, 10'b1000000000);
        run_to(80, 1);
        step();
        check("bar_yel_b", dec(tmds_ch0), 8'h00);
        check("bar_yel_g", dec(tmds_ch1), 8'hFF);
        check("bar_yel_r", dec(tmds_ch2), 8'hFF);
        run_to(480, 1);
        step();
        check("bar_blue_b", dec(tmds_ch0), 8'hFF);
        check("bar_blue_g", dec(tmds_ch1), 8'h00);
        check("bar_blue_r", dec(tmds_ch2), 8'h00);
        run_to(560, 1);
        step();
        check("bar_blk_b", dec(tmds_ch0), 8'h00);
        check("bar_blk_g", dec(tmds_ch1), 8'h00);
        check("bar_blk_r", dec(tmds_ch2), 8'h00);
`else
        rgb_r = 8'hA5; rgb_g = 8'h3C; rgb_b = 8'h0F;
        run_to(300, 1);
        test_mode = 1'b1;
        step();
        check("tm_ign_b", dec(tmds_ch0), 8'h0F);
        check("tm_ign_g", dec(tmds_ch1), 8'h3C);
        check("tm_ign_r", dec(tmds_ch2), 8'hA5);
`endif
        run_to(600, 1);
        test_mode = 1'b0;
        rgb_r = 8'h12; rgb_g = 8'h34; rgb_b = 8'h56;
        step();
        check("pass_b", dec(tmds_ch0), 8'h56);
        check("pass_g", dec(tmds_ch1), 8'h34);
        check("pass_r", dec(tmds_ch2), 8'h12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tmds_link_ctrl.md
# tmds_link_ctrl

Video link controller that sequences three TMDS encoder channels into a DVI/HDMI-style serial-ready symbol stream. It generates raster timing (h/v counters, DE, HSYNC, VSYNC) and exposes the current pixel coordinate to the pixel source. It samples the returned RGB, keeps one running-disparity register per channel, and registers the three 10-bit symbols for the downstream serializer. It sits between the frame/pixel generator and the serializer/OSERDES stage.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync level during pulse (0 = active-low)
- VS_POL, 0, vsync level during pulse

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; low synchronously clears counters and blanks output
- test_mode  in  1  select built-in colour bars (see Configuration)
- rgb_r, rgb_g, rgb_b  in  8 each  pixel for current px_x/px_y
- px_x  out  12  current horizontal count
- px_y  out  12  current vertical count
- px_de  out  1  current position is active video
- hsync, vsync  out  1 each  sync levels after polarity
- frame_start  out  1  one-cycle pulse at h=0, v=0 while en=1
- tmds_ch0, tmds_ch1, tmds_ch2  out  10 each  registered symbols, blue/green/red

## Operation
- h_cnt, v_cnt: 12-bit registers. H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise. h_cnt increments each en cycle and wraps H_TOTAL-1 → 0. v_cnt increments on h wrap and wraps V_TOTAL-1 → 0.
- Region order per axis: active [0, ACTIVE), front porch, sync, back porch.
- px_de = en & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE). px_x = h_cnt, px_y = v_cnt; combinational decode of the counter registers.
- hsync = HS_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL. vsync uses the same rule on v_cnt. Both are forced to their inactive level when en=0.
- Encoding, three instances of the team TMDS encoder: d = channel colour, de = px_de.
  - ch0 (blue): c0 = hsync, c1 = vsync.
  - ch1 and ch2: c0 = c1 = 0.
  - cnt_prev comes from that channel's 5-bit signed disparity register; the encoder's cnt output is written back each cycle. Disparity is therefore cleared whenever de=0.
- en=0: counters held at 0, px_de=0, symbols are control codes with inactive sync. On re-enable, a fresh frame starts at (0,0).

## Timing
- Reset values: h_cnt=v_cnt=0, all disparity registers 0, tmds_ch0/1/2 = 10'b1101010100.
- Combinational outputs after reset, with en=1: px_x=0, px_y=0, px_de=1, frame_start=1.
- Latency: rgb is sampled with px_* in cycle t. The symbol appears on tmds_chN after the clock edge ending cycle t (1 cycle). Disparity is updated on the same edge.
- No stall/handshake: the pixel source must present rgb combinationally or pre-fetched for the same cycle.
- rst dominates en. A mid-frame rst restarts at (0,0) with disparity 0 and the control symbol on the next cycle.
- frame_start period = H_TOTAL*V_TOTAL cycles (420000 at defaults).

## Configuration
- TMDS_LINK_CTRL_PATTERN_EN defined: when test_mode=1, rgb inputs are replaced by 8 vertical bars, each H_ACTIVE/8 wide, left to right: white, yellow, cyan, green, magenta, red, blue, black (components 0xFF/0x00).
  - Bar boundaries are comparisons against parameter-derived constants; no divider.
- Macro undefined: bar logic is absent; test_mode is ignored and rgb inputs are always used.

## Test plan
- Counter wrap, defaults: after reset with en=1, px_x steps 0..799 then 0 while px_y increments. px_y wraps 524→0. frame_start pulses exactly every 420000 cycles.
- Disparity sequence, rgb=0x000000 at the first active pixels: first tmds_ch0=10'b0100000000 with disparity −8; second = 10'b1111111111 with disparity +2.
- Sync symbols, defaults (active-low):
  - h_cnt in 656..751 with v_cnt=0: tmds_ch0 = 10'b0101010100.
  - hsync and vsync both active (v_cnt 490..491): tmds_ch0 = 10'b1101010100.
  - Outside any sync pulse during blanking: tmds_ch0 = 10'b1010101011.
  - tmds_ch1/ch2 = 10'b1101010100 throughout blanking.
- en dropped mid-line at h_cnt=300: the next cycle gives px_de=0, counters at 0, control symbols on all channels, disparity 0. Re-raising en gives frame_start=1 the same cycle.
- rst asserted at v_cnt=200: the next cycle gives all tmds_ch = 10'b1101010100 and counters 0.
- With the macro defined and test_mode=1: px_x=0 encodes 0xFF on all channels; px_x=560 encodes 0x00 on all channels. With test_mode=0, the rgb input passes through.
